fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues requests to instruction memory and loads the IF/ID register.
//  Feeds decode and the jump extender: if_jtarget (instr[25:0]) and if_pc_plus4 form the jump address downstream.
//  Accepts the resolved jump/branch target back as redirect_pc.
//  Handles a variable-latency memory, decode stalls and redirects that arrive while a request is outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; word aligned.
// PORTS
//  clk             in   1   clock, rising edge
//  reset_n         in   1   asynchronous active-low reset
//  stall           in   1   decode hazard; IF/ID must hold
//  redirect_valid  in   1   taken jump/branch this cycle
//  redirect_pc     in   32  new PC; bits [1:0] ignored, forced 0
//  imem_req        out  1   fetch request
//  imem_addr       out  32  fetch address; stable while imem_req=1 and imem_ack=0
//  imem_ack        in   1   data valid; may be same cycle as req
//  imem_rdata      in   32  instruction word, valid with imem_ack
//  if_valid        out  1   IF/ID holds a live instruction
//  if_instr        out  32  IF/ID instruction
//  if_pc           out  32  address of if_instr
//  if_pc_plus4     out  32  if_pc + 4, mod 2^32
//  if_jtarget      out  26  if_instr[25:0]
//  fetch_count     out  32  delivered-instruction counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, state=FETCH.
//   Outputs under reset: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4, fetch_count=0.
//   Reset mid-request discards the request; memory must tolerate req dropping.
//  States: FETCH, HOLD, DRAIN.
//  FETCH: imem_req=1, imem_addr=pc.
//   - ack & (!stall | !if_valid): IF/ID <= {rdata, pc}; if_valid=1; pc+=4; stay in FETCH.
//   - ack & stall & if_valid: rdata/pc go to the skid buffer; pc+=4; go to HOLD.
//   - no ack: hold pc/addr.
//  HOLD: imem_req=0; IF/ID unchanged. When !stall: IF/ID <= skid buffer; go to FETCH.
//  DRAIN: imem_req=1 with the OLD address, waiting for the outstanding ack. On ack, the data is discarded, pc=pending target, go to FETCH.
//  Redirect rules (checked before the rules above):
//   - FETCH with ack, or HOLD: pc<=redirect_pc; if_valid<=0; skid buffer dropped; ack data dropped; go to FETCH.
//   - FETCH without ack: latch target; if_valid<=0; go to DRAIN. A second redirect in DRAIN overwrites the latched target.
//  A redirect overrides stall: IF/ID is squashed even while stall=1.
//  Latency: ack in cycle N gives if_valid/if_instr at N+1. Back-to-back acks sustain 1 instr/cycle.
//  The pc wraps 0xFFFF_FFFC -> 0x0000_0000 with no error.
//  stall while if_valid=0 is ignored: the empty IF/ID always loads.
// CONFIGURATION
//  FETCH_COUNT_EN defined: fetch_count increments by 1 each time IF/ID loads a live instruction.
//   Squashed, dropped and DRAIN words are not counted; the counter wraps at 2^32; reset to 0.
//  FETCH_COUNT_EN undefined: fetch_count tied to 32'h0; no counter flops.
// TESTING
//  1 reset_n=0 mid-fetch -> imem_req=0, if_valid=0 at once; release -> first req addr=RESET_PC.
//  2 ack every cycle, rdata 0x20080001,0x20090002 -> if_pc 0,4; if_pc_plus4 4,8; imem_addr 0,4,8.
//  3 stall=1 while ack of addr 4 arrives -> state HOLD, imem_req=0, if_instr stays word@0;
//    stall=0 -> if_instr=word@4, next imem_addr=8.
//  4 if_instr=0x08000010 with redirect_pc=0x40 and ack -> next cycle if_valid=0, imem_addr=0x40.
//  5 memory latency 3, redirect 0x40 in the 1st wait cycle -> addr held until ack, data dropped, then addr 0x40.
//  6 FETCH_COUNT_EN on, 5 delivered + 1 squashed -> fetch_count=5; macro off -> 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, IF/ID register, skid buffer and redirect draining.
// Optional FETCH_COUNT_EN adds a delivered-instruction counter on fetch_count.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [25:0] if_jtarget,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
   logic [31:0] instr_q, instr_d, ifpc_q, ifpc_d;
   logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
   logic        valid_q, valid_d, load;
   logic [31:0] rpc;
   logic        unused_bits;
   assign rpc         = {redirect_pc[31:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];
   // reset gates the request combinationally so it drops the instant reset_n falls
   assign imem_req    = reset_n & (state_q != HOLD);
   assign imem_addr   = pc_q;
   assign if_valid    = valid_q;
   assign if_instr    = instr_q;
   assign if_pc       = ifpc_q;
   assign if_pc_plus4 = ifpc_q + 32'd4;
   assign if_jtarget  = instr_q[25:0];
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      ifpc_d       = ifpc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      load         = 1'b0;
      case (state_q)
         FETCH: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               if (imem_ack) pc_d = rpc;
               else begin
                  tgt_d   = rpc;
                  state_d = DRAIN;
               end
            end else if (imem_ack) begin
               pc_d = pc_q + 32'd4;
               if (!stall || !valid_q) begin
                  load    = 1'b1;
                  instr_d = imem_rdata;
                  ifpc_d  = pc_q;
                  valid_d = 1'b1;
               end else begin
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = pc_q;
                  state_d      = HOLD;
               end
            end else if (!stall) valid_d = 1'b0;
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = rpc;
               valid_d = 1'b0;
               state_d = FETCH;
            end else if (!stall) begin
               load    = 1'b1;
               instr_d = skid_instr_q;
               ifpc_d  = skid_pc_q;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (imem_ack) begin
               pc_d    = redirect_valid ? rpc : tgt_q;
               state_d = FETCH;
            end else if (redirect_valid) tgt_d = rpc;
         end
         default: state_d = FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         tgt_q        <= RESET_PC;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         ifpc_q       <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tgt_q        <= tgt_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         ifpc_q       <= ifpc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end
`ifdef FETCH_COUNT_EN
   logic [31:0] cnt_q, cnt_d;
   assign cnt_d       = cnt_q + {31'd0, load};
   assign fetch_count = cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
`else
   logic unused_load;
   assign unused_load = load;
   assign fetch_count = 32'h0;
`endif
endmodule
